// File: rtl/mst_imp_w_ch.sv
// Single-channel AXI write master: takes words from a pixel stream and writes
// them one at a time into a 2D destination region (HSIZE words x VSIZE rows,
// rows PITCH bytes apart). Exactly one transaction is outstanding at any time.
module mst_imp_w_ch (
    input  logic        clk,
    input  logic        PoR_rst_n,
    input  logic [7:0]  IMP_HSIZE,
    input  logic [7:0]  IMP_VSIZE,
    input  logic        IMP_ST,
    input  logic [31:0] IMP_DST_BADDR,
    input  logic [31:0] IMP_ADR_PITCH,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [31:0] pix_data,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    input  logic [1:0]  mem_axi_bresp,
    output logic        imp_busy,
    output logic        imp_done,
    output logic        imp_err
);

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, RESP, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  st_hist_q;
    logic [7:0]  hsize_q, hsize_d, vsize_q, vsize_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [31:0] pitch_q, pitch_d, row_base_q, row_base_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic        err_q, err_d;
    logic        wstrb_en_q;
    logic        trig, aw_done, w_done, row_end, last_word;

    // Rising edge of IMP_ST as seen through the 2-stage history.
    assign trig      = (st_hist_q == 2'b01);
    // A channel is done once its valid has dropped or it is handshaking now.
    assign aw_done   = !awvalid_q || mem_axi_awready;
    assign w_done    = !wvalid_q  || mem_axi_wready;
    assign row_end   = (x_q == hsize_q - 8'd1);
    assign last_word = row_end && (y_q == vsize_q - 8'd1);

    // Next-state and datapath updates; everything holds unless a case overrides.
    always_comb begin
        state_d    = state_q;
        hsize_d    = hsize_q;
        vsize_d    = vsize_q;
        pitch_d    = pitch_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    hsize_d = IMP_HSIZE;
                    vsize_d = IMP_VSIZE;
                    pitch_d = IMP_ADR_PITCH;
                    if (IMP_HSIZE == 8'd0 || IMP_VSIZE == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = FILL;
                        x_d        = 8'd0;
                        y_d        = 8'd0;
                        row_base_d = IMP_DST_BADDR;
                        err_d      = 1'b0;
                    end
                end
            end
            FILL: begin
                if (pix_valid) begin
                    wdata_d   = pix_data;
                    awaddr_d  = row_base_q + {22'd0, x_q, 2'b00};
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (awvalid_q && mem_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && mem_axi_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done)            state_d   = RESP;
            end
            RESP: begin
                if (mem_axi_bvalid) begin
                    if (mem_axi_bresp != 2'b00) err_d = 1'b1;
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                        if (row_end) begin
                            x_d        = 8'd0;
                            y_d        = y_q + 8'd1;
                            row_base_d = row_base_q + pitch_q;
                        end else begin
                            x_d = x_q + 8'd1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the power-on reset.
    always_ff @(posedge clk or negedge PoR_rst_n) begin
        if (!PoR_rst_n) begin
            state_q    <= IDLE;
            st_hist_q  <= 2'b00;
            hsize_q    <= 8'd0;
            vsize_q    <= 8'd0;
            pitch_q    <= 32'd0;
            x_q        <= 8'd0;
            y_q        <= 8'd0;
            row_base_q <= 32'd0;
            awaddr_q   <= 32'd0;
            wdata_q    <= 32'd0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            wstrb_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_hist_q  <= {st_hist_q[0], IMP_ST};
            hsize_q    <= hsize_d;
            vsize_q    <= vsize_d;
            pitch_q    <= pitch_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            err_q      <= err_d;
            wstrb_en_q <= 1'b1;
        end
    end

    assign pix_ready       = (state_q == FILL);
    assign mem_axi_bready  = (state_q == RESP);
    assign imp_busy        = (state_q != IDLE);
    assign imp_done        = (state_q == DONE);
    assign imp_err         = err_q;
    assign mem_axi_awvalid = awvalid_q;
    assign mem_axi_wvalid  = wvalid_q;
    assign mem_axi_awaddr  = awaddr_q;
    assign mem_axi_wdata   = wdata_q;
    assign mem_axi_awprot  = 3'b000;
    // Full-word strobes, but forced low while reset holds every output at zero.
    assign mem_axi_wstrb   = wstrb_en_q ? 4'hF : 4'h0;

endmodule
